// File: rtl/miniaig_tt_pkg.sv
// Shared types and helpers for the MiniAig truth-table capture block.
package miniaig_tt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } tt_state_e;

    localparam int MAX_LAT = 7;

    function automatic int tt_w(input int n_pi);
        return 1 << n_pi;
    endfunction

endpackage

// File: rtl/miniaig_delay_line.sv
// Fixed-depth shift register with async reset; DEPTH=0 degenerates to a wire.
module miniaig_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign q = d;
        end else begin : g_pipe
            logic [W-1:0] stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/miniaig_tt_capture.sv
// Exhaustive input sweep of a combinational MiniAig netlist; packs po0 responses
// into a truth table and compares it against a golden table.
module miniaig_tt_capture
    import miniaig_tt_pkg::*;
#(
    parameter int N_PI = 5,
    parameter int LAT  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic [N_PI-1:0]          pi_drive,
    input  logic                     po_sample,
    input  logic [tt_w(N_PI)-1:0]    exp_tt,
    output logic [tt_w(N_PI)-1:0]    tt,
    output logic                     tt_valid,
    input  logic                     tt_ack,
    output logic                     match,
    output logic [N_PI-1:0]          fail_idx
);

    localparam int TT_W = tt_w(N_PI);
    localparam logic [2:0] DRAIN_LAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    tt_state_e         state;
    logic [N_PI:0]     cnt;
    logic [N_PI:0]     cnt_inc;
    logic [2:0]        drain_cnt;
    logic [TT_W-1:0]   exp_q;
    logic [TT_W-1:0]   diff;
    logic [N_PI:0]     pipe_d;
    logic [N_PI:0]     pipe_q;
    logic              cap_valid;
    logic [N_PI-1:0]   cap_idx;
    logic [N_PI-1:0]   lowest_idx;

    // The extra counter bit flags that the last pattern has had its full cycle.
    assign cnt_inc = cnt + 1'b1;

    // {valid, index} travels LAT cycles so each capture lines up with its pattern.
    assign pipe_d = {state == SWEEP, pi_drive};

    miniaig_delay_line #(
        .W     (N_PI + 1),
        .DEPTH (LAT)
    ) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pipe_d),
        .q     (pipe_q)
    );

    assign cap_valid = pipe_q[N_PI];
    assign cap_idx   = pipe_q[N_PI-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            drain_cnt <= '0;
            pi_drive  <= '0;
            exp_q     <= '0;
            busy      <= 1'b0;
            tt_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SWEEP;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        pi_drive <= '0;
                        exp_q    <= exp_tt;
                    end
                end
                SWEEP: begin
                    cnt <= cnt_inc;
                    if (cnt_inc[N_PI]) begin
                        // pi_drive parks on the last pattern rather than wrapping.
                        if (LAT > 0) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            state    <= HOLD;
                            busy     <= 1'b0;
                            tt_valid <= 1'b1;
                        end
                    end else begin
                        pi_drive <= cnt_inc[N_PI-1:0];
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state    <= HOLD;
                        busy     <= 1'b0;
                        tt_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                HOLD: begin
                    if (tt_ack) begin
                        state    <= IDLE;
                        tt_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt <= '0;
        end else if (state == IDLE && start) begin
            tt <= '0;
        end else if ((state == SWEEP || state == DRAIN) && cap_valid) begin
            tt[cap_idx] <= po_sample;
        end
    end

    assign diff = tt ^ exp_q;

    // Descending scan so the lowest differing bit has the final word.
    always_comb begin
        lowest_idx = '0;
        for (int i = TT_W - 1; i >= 0; i--) begin
            if (diff[i]) begin
                lowest_idx = i[N_PI-1:0];
            end
        end
    end

    assign match    = tt_valid && (diff == '0);
    assign fail_idx = tt_valid ? lowest_idx : '0;

endmodule

// File: tb/tb_miniaig_tt_capture.sv
// Directed bench for miniaig_tt_capture: a LAT=0 instance on a combinational
// netlist and a LAT=3 instance on a three-stage registered netlist.
module tb_miniaig_tt_capture;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // LAT=0 instance
    logic        start0, ack0, busy0, v0, m0, po0;
    logic [4:0]  pi0, f0;
    logic [31:0] exp_tt0, tt0;

    // LAT=3 instance
    logic        start3, ack3, busy3, v3, m3, po3, flip3;
    logic [4:0]  pi3, f3;
    logic [31:0] exp_tt3, tt3;
    logic [2:0]  pp3;

    int total = 0;
    int bad   = 0;

    // {due_edge[15:0], fail_idx[4:0], match, tt[31:0]}
    logic [53:0] exp_q0[$];
    logic [53:0] exp_q3[$];
    logic [53:0] e0, e3;
    logic        pv0 = 1'b0;
    logic        pv3 = 1'b0;

    localparam logic [31:0] F_TT = 32'hF888F888;

    // Netlist under test: f = (pi0 & pi1) | (pi2 & pi3)
    assign po0 = (pi0[0] & pi0[1]) | (pi0[2] & pi0[3]);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pp3 <= 3'b000;
        else        pp3 <= {pp3[1:0], ((pi3[0] & pi3[1]) | (pi3[2] & pi3[3])) ^ flip3};
    end
    assign po3 = pp3[2];

    miniaig_tt_capture #(.N_PI(5), .LAT(0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start0),
        .busy      (busy0),
        .pi_drive  (pi0),
        .po_sample (po0),
        .exp_tt    (exp_tt0),
        .tt        (tt0),
        .tt_valid  (v0),
        .tt_ack    (ack0),
        .match     (m0),
        .fail_idx  (f0)
    );

    miniaig_tt_capture #(.N_PI(5), .LAT(3)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start3),
        .busy      (busy3),
        .pi_drive  (pi3),
        .po_sample (po3),
        .exp_tt    (exp_tt3),
        .tt        (tt3),
        .tt_valid  (v3),
        .tt_ack    (ack3),
        .match     (m3),
        .fail_idx  (f3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: compare on every tt_valid rising edge.
    always @(negedge clk) begin
        if (v0 === 1'b1 && pv0 !== 1'b1) begin
            if (exp_q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut0_unexpected_valid: got tt=%0h at edge %0d, expected no result", tt0, cyc);
            end else begin
                e0 = exp_q0.pop_front();
                check("dut0_tt", tt0, e0[31:0]);
                check("dut0_match", m0, e0[32]);
                check("dut0_fail_idx", f0, e0[37:33]);
                check("dut0_latency", cyc[15:0], e0[53:38]);
                check("dut0_busy_in_hold", busy0, 0);
            end
        end
        pv0 = v0;
    end

    always @(negedge clk) begin
        if (v3 === 1'b1 && pv3 !== 1'b1) begin
            if (exp_q3.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut3_unexpected_valid: got tt=%0h at edge %0d, expected no result", tt3, cyc);
            end else begin
                e3 = exp_q3.pop_front();
                check("dut3_tt", tt3, e3[31:0]);
                check("dut3_match", m3, e3[32]);
                check("dut3_fail_idx", f3, e3[37:33]);
                check("dut3_latency", cyc[15:0], e3[53:38]);
                check("dut3_busy_in_hold", busy3, 0);
            end
        end
        pv3 = v3;
    end

    // Driver tasks; all are entered and left on a falling edge.
    task automatic do_start(input int sel, output int k);
        @(negedge clk);
        if (sel == 0) start0 = 1'b1;
        else          start3 = 1'b1;
        @(negedge clk);
        k = cyc;
        start0 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_valid(input int sel, input string name);
        int n = 0;
        while (((sel == 0) ? v0 : v3) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, (sel == 0) ? v0 : v3, 1);
    endtask

    task automatic do_ack(input int sel, input string name);
        if (sel == 0) ack0 = 1'b1;
        else          ack3 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
        ack3 = 1'b0;
        if (sel == 0) check({name, "_idle_after_ack"}, {v0, busy0}, 0);
        else          check({name, "_idle_after_ack"}, {v3, busy3}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        rst_n   = 1'b0;
        start0  = 1'b0; ack0 = 1'b0; exp_tt0 = '0;
        start3  = 1'b0; ack3 = 1'b0; exp_tt3 = '0; flip3 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dut0_outs", {busy0, pi0, tt0, v0, m0, f0}, 0);
        check("reset_dut3_outs", {busy3, pi3, tt3, v3, m3, f3}, 0);
        rst_n = 1'b1;

        // A: matching golden table
        exp_tt0 = F_TT;
        do_start(0, k);
        exp_q0.push_back({16'(k + 32), 5'd0, 1'b1, F_TT});
        check("a_busy_in_sweep", busy0, 1);
        wait_valid(0, "a_valid");
        do_ack(0, "a");

        // B: golden differs in bit 0
        exp_tt0 = 32'hF888F889;
        do_start(0, k);
        exp_q0.push_back({16'(k + 32), 5'd0, 1'b0, F_TT});
        wait_valid(0, "b_valid");
        do_ack(0, "b");

        // C: golden differs in bit 6; long hold with a stray start
        exp_tt0 = 32'hF888F8C8;
        do_start(0, k);
        exp_q0.push_back({16'(k + 32), 5'd6, 1'b0, F_TT});
        wait_valid(0, "c_valid");
        for (int i = 0; i < 10; i++) begin
            start0 = (i == 4);
            @(negedge clk);
            check("c_hold_valid", v0, 1);
            check("c_hold_tt", tt0, F_TT);
        end
        start0 = 1'b0;
        check("c_hold_fail_idx", f0, 6);
        do_ack(0, "c");
        repeat (3) @(negedge clk);
        check("c_start_in_hold_ignored", busy0, 0);
        check("c_tt_kept_after_ack", tt0, F_TT);

        // D: LAT=3 instance; then no capture in IDLE while the netlist flips
        exp_tt3 = F_TT;
        do_start(1, k);
        exp_q3.push_back({16'(k + 35), 5'd0, 1'b1, F_TT});
        wait_valid(1, "d_valid");
        do_ack(1, "d");
        flip3 = 1'b1;
        repeat (6) @(negedge clk);
        check("d_no_capture_in_idle", tt3, F_TT);
        flip3 = 1'b0;

        // E: async abort at pattern 17, then a clean sweep
        exp_tt0 = F_TT;
        do_start(0, k);
        n = 0;
        while (pi0 !== 5'd17 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("e_reached_17", pi0, 17);
        #2 rst_n = 1'b0;
        #1;
        check("e_abort_outs", {busy0, pi0, tt0, v0, m0, f0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("e_idle_after_abort", {busy0, v0}, 0);
        do_start(0, k);
        exp_q0.push_back({16'(k + 32), 5'd0, 1'b1, F_TT});
        wait_valid(0, "e_valid");
        do_ack(0, "e");

        // F: start and ack held high -> back-to-back sweeps, one IDLE cycle apart
        @(negedge clk);
        ack0   = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        k = cyc;
        exp_q0.push_back({16'(k + 32), 5'd0, 1'b1, F_TT});
        exp_q0.push_back({16'(k + 66), 5'd0, 1'b1, F_TT});
        wait_valid(0, "f1_valid");
        @(negedge clk);
        check("f_gap_idle", {v0, busy0}, 0);
        @(negedge clk);
        check("f_resweep_busy", busy0, 1);
        start0 = 1'b0;
        wait_valid(0, "f2_valid");
        @(negedge clk);
        check("f_end_idle", {v0, busy0}, 0);
        ack0 = 1'b0;
        repeat (3) @(negedge clk);
        check("f_stays_idle", busy0, 0);

        check("q0_drained", exp_q0.size(), 0);
        check("q3_drained", exp_q3.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
